coin_acceptor: RTL
==================

// Module: coin_acceptor
// PURPOSE
//  Front end of the vending machine: turns raw, bouncy coin-slot sensor lines into clean nickel/dime/quarter pulses.
//  Each pulse is one cycle wide and at most one is asserted per cycle. These pulses are the coin inputs of the vending FSM.
//  Coins are buffered in a FIFO while the vending FSM is busy (e.g. delivering or giving change).
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable cycles needed before a debounced sensor changes (>=1)
//  FIFO_DEPTH       4  coin events buffered (power of 2, >=2)
//  GAP_CYCLES       1  idle cycles forced between consecutive output pulses (>=0)
// PORTS
//  clock          in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-low; clears all state
//  sense_nickel   in   1  raw nickel-slot sensor, asynchronous to clock
//  sense_dime     in   1  raw dime-slot sensor, asynchronous
//  sense_quarter  in   1  raw quarter-slot sensor, asynchronous
//  busy           in   1  vending FSM cannot take a coin this cycle; holds output side
//  nickel         out  1  one-cycle coin pulse to vending FSM
//  dime           out  1  one-cycle coin pulse
//  quarter        out  1  one-cycle coin pulse
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  queued coin count
//  overflow       out  1  sticky: a coin event was lost
//  coin_reject    out  1  one-cycle jam pulse (only with COIN_REJECT_EN; else tied 0)
// BEHAVIOUR
//  Reset values:
//   - nickel/dime/quarter/overflow/coin_reject = 0; fifo_level = 0.
//   - FSM in IDLE.
//   - Debounced states = 1 per channel, so a sensor held high across reset never yields a coin.
//  Input path, per channel:
//   - Sync: 2-flop synchroniser.
//   - Debounce: counter, width $clog2(DEBOUNCE_CYCLES+1). Counts cycles where synced != debounced and clears on any match.
//     At DEBOUNCE_CYCLES the debounced state flips and the counter clears.
//   - Edge: a 0->1 debounced transition is a coin event and sets that channel's pending flag.
//  Pending/FIFO:
//   - Arbiter pushes one pending flag per cycle into the FIFO when it is not full, priority quarter > dime > nickel.
//     The pushed flag clears.
//   - Full FIFO: pending flags wait; nothing is lost.
//   - An event on a channel whose pending flag is already set is lost and sets overflow. overflow clears only on reset.
//   - Push and pop in the same cycle are legal; level unchanged.
//   - Codes stored 2 bits: 01 nickel, 10 dime, 11 quarter.
//  Output FSM (outputs registered; exactly one of nickel/dime/quarter high in EMIT):
//   - IDLE: FIFO non-empty and busy=0 -> pop, EMIT.
//   - EMIT (1 cycle): -> GAP if GAP_CYCLES>0, else IDLE.
//   - GAP: counts GAP_CYCLES cycles regardless of busy -> IDLE.
//   - busy is sampled only in IDLE; a pulse already in EMIT completes.
//  Latency: empty FIFO, IDLE, busy=0, sensor rises and is stable -> output pulse high DEBOUNCE_CYCLES+4 edges after the first edge sampling it high.
//  Reset asserted mid-operation: immediate clear, including in-flight EMIT pulses and FIFO contents.
//  Order: coins leave in FIFO order; no duplication, no reordering.
// CONFIGURATION
//  COIN_REJECT_EN:
//   - Defined: coin events on two or more channels in the same cycle are a jam.
//     None of them is queued, the pending flags are untouched, and coin_reject pulses 1 cycle.
//   - Undefined: all simultaneous events are queued, in order quarter, dime, nickel; coin_reject is constant 0.
// TESTING  (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, GAP_CYCLES=1)
//  1. Reset, then sense_nickel high for 6 cycles, busy=0 -> nickel=1 for exactly 1 cycle, 8 edges after rise; dime=quarter=0.
//  2. sense_dime bounces (1,1,0,1,1,0), then stable high for 6 cycles -> exactly one dime pulse, none during the bounce.
//  3. All three sensors rise in the same cycle:
//     - Without macro: pulses quarter, idle, dime, idle, nickel.
//     - With COIN_REJECT_EN: no coin pulses; coin_reject=1 for 1 cycle.
//  4. busy=1, five coins inserted one at a time (N,D,Q,N,D):
//     - fifo_level reaches 4, the 5th stays pending, overflow=0.
//     - busy=0 -> N,D,Q,N,D emitted in order, 1 idle cycle apart.
//  5. busy=1, FIFO full and nickel pending, a second nickel inserted -> overflow=1; it stays 1 after busy=0, until reset.
//  6. Reset asserted during EMIT with sense_quarter held high through release:
//     - Outputs go 0 at once; fifo_level=0.
//     - No quarter pulse after release.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Vending-machine coin front end. Each raw slot sensor goes through a
//   2-flop synchroniser and a stability debouncer. A rising debounced sensor
//   is a coin event, which sets a per-channel pending flag. A fixed-priority
//   arbiter (quarter > dime > nickel) moves pending coins into a small FIFO.
//   An output FSM pops the FIFO and produces registered one-cycle coin
//   pulses, with a forced idle gap between pulses.
//
// Ports
//   clock          in   rising-edge system clock
//   reset          in   asynchronous, active-low; clears all state
//   sense_nickel   in   raw nickel-slot sensor (asynchronous)
//   sense_dime     in   raw dime-slot sensor (asynchronous)
//   sense_quarter  in   raw quarter-slot sensor (asynchronous)
//   busy           in   downstream cannot accept a coin (sampled in IDLE only)
//   nickel         out  one-cycle nickel pulse
//   dime           out  one-cycle dime pulse
//   quarter        out  one-cycle quarter pulse
//   fifo_level     out  number of queued coins
//   overflow       out  sticky: a coin event was lost
//   coin_reject    out  one-cycle jam pulse (constant 0 unless COIN_REJECT_EN)
//
// Build option
//   COIN_REJECT_EN : when defined, coin events on two or more channels in the
//                    same cycle are rejected as a jam instead of queued.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sense_nickel,
  input  logic                          sense_dime,
  input  logic                          sense_quarter,
  input  logic                          busy,
  output logic                          nickel,
  output logic                          dime,
  output logic                          quarter,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          coin_reject
);

  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GCNT_END = GW'(GAP_LAST);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

  // channel index: 0 nickel, 1 dime, 2 quarter
  logic [2:0]    sense;
  logic [2:0]    sync_p0, sync_p1, deb;
  logic [DW-1:0] cnt [3];
  logic [2:0]    rise, evt, pend, pend_clr, pend_nxt, lost;
  logic          jam, push, pop;
  logic [1:0]    push_code, coin_d;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state, state_nxt;
  logic [GW-1:0] gcnt;
  logic          take_ok, nickel_d, dime_d, quarter_d;

  assign sense = {sense_quarter, sense_dime, sense_nickel};

  // ---- stage p0/p1: synchroniser, then debounce ----
  // Debounced state resets high so a sensor held high across reset is not a coin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      deb     <= '1;
      for (int c = 0; c < 3; c++) cnt[c] <= '0;
    end else begin
      sync_p0 <= sense;
      sync_p1 <= sync_p0;
      for (int c = 0; c < 3; c++) begin
        if (sync_p1[c] == deb[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == CNT_LAST) begin
          deb[c] <= sync_p1[c];
          cnt[c] <= '0;
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end

  // A coin event is flagged in the same cycle the debounced state flips 0->1,
  // so the pending flag is set on the flip edge itself.
  always_comb begin
    rise = '0;
    for (int c = 0; c < 3; c++)
      rise[c] = sync_p1[c] & ~deb[c] & (cnt[c] == CNT_LAST);
  end

`ifdef COIN_REJECT_EN
  assign jam = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) coin_reject <= 1'b0;
    else        coin_reject <= jam;
  end
`else
  assign jam         = 1'b0;
  assign coin_reject = 1'b0;
`endif

  // ---- stage: pending flags and arbiter into the FIFO ----
  always_comb begin
    pend_clr  = '0;
    push      = 1'b0;
    push_code = 2'b00;
    if (fifo_level != FULL_LVL) begin
      if (pend[2]) begin
        pend_clr = 3'b100; push = 1'b1; push_code = 2'b11;
      end else if (pend[1]) begin
        pend_clr = 3'b010; push = 1'b1; push_code = 2'b10;
      end else if (pend[0]) begin
        pend_clr = 3'b001; push = 1'b1; push_code = 2'b01;
      end
    end
  end

  // A flag leaving for the FIFO this cycle can take a new event without loss.
  assign evt      = jam ? 3'b000 : rise;
  assign lost     = evt & pend & ~pend_clr;
  assign pend_nxt = (pend & ~pend_clr) | evt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      overflow <= overflow | (|lost);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // ---- stage: output FSM ----
  // The IDLE cycle that follows EMIT/GAP is itself the last forced idle cycle,
  // so GAP holds GAP_CYCLES-1 cycles and pulses come GAP_CYCLES idle cycles
  // apart. With no gap at all, EMIT may pop directly for back-to-back pulses.
  assign take_ok = (state == S_IDLE) || ((GAP_CYCLES == 0) && (state == S_EMIT));
  assign pop     = take_ok && (fifo_level != '0) && !busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      gcnt    <= '0;
      nickel  <= 1'b0;
      dime    <= 1'b0;
      quarter <= 1'b0;
    end else begin
      state   <= state_nxt;
      gcnt    <= (state == S_GAP) ? gcnt + 1'b1 : '0;
      nickel  <= nickel_d;
      dime    <= dime_d;
      quarter <= quarter_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_EMIT;
      S_EMIT:  begin
        if (pop)                 state_nxt = S_EMIT;
        else if (GAP_CYCLES > 1) state_nxt = S_GAP;
        else                     state_nxt = S_IDLE;
      end
      S_GAP:   if (gcnt == GCNT_END) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    coin_d    = pop ? mem[rd_ptr] : 2'b00;
    nickel_d  = (coin_d == 2'b01);
    dime_d    = (coin_d == 2'b10);
    quarter_d = (coin_d == 2'b11);
  end

endmodule
